// File: rtl/fg_pkg.sv
// Shared types and constants for the foreground fetch stage.
package fg_pkg;

  localparam int unsigned PIXEL_W       = 16;
  localparam int unsigned FG_WIDTH_DEF  = 640;
  localparam int unsigned FG_HEIGHT_DEF = 480;

  // Outcome of the S1 issue decision; travels alongside the read data.
  typedef enum logic [1:0] {
    TAG_INVALID = 2'd0,
    TAG_READ    = 2'd1,
    TAG_REUSE   = 2'd2,
    TAG_DROP    = 2'd3
  } fg_tag_e;

endpackage

// File: rtl/fg_sram_reader_if.sv
// Read side of the shared foreground SRAM: address/strobe out, data and writer-busy in.
interface fg_sram_reader_if #(
  parameter int unsigned ADDR_W = 19
);
  import fg_pkg::*;

  logic [ADDR_W-1:0]  sram_addr;
  logic               sram_rd_en;
  logic [PIXEL_W-1:0] sram_rdata;
  logic               sram_busy;

  modport master (
    output sram_addr,
    output sram_rd_en,
    input  sram_rdata,
    input  sram_busy
  );

  modport slave (
    input  sram_addr,
    input  sram_rd_en,
    output sram_rdata,
    output sram_busy
  );

endinterface

// File: rtl/fg_addr_gen.sv
// S0 request register with bounds check; S1 address is formed from the registered request.
module fg_addr_gen #(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned FG_WIDTH  = 640,
  parameter int unsigned FG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic              req_active,
  input  logic [ADDR_W-1:0] fg_base_addr,
  output logic              s1_valid,
  output logic [ADDR_W-1:0] s1_addr
);

  logic [9:0]        x_q, y_q;
  logic              active_q, in_range_q;
  logic              in_range;
  logic [ADDR_W-1:0] y_ext, row_off;

  assign in_range = (32'(req_x) < FG_WIDTH) && (32'(req_y) < FG_HEIGHT);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      x_q        <= req_x;
      y_q        <= req_y;
      active_q   <= req_active;
      in_range_q <= in_range;
    end
  end

  assign y_ext = ADDR_W'(y_q);

  // A 640-wide stride is 512 + 128, so two shifts replace the multiplier.
  if (FG_WIDTH == 640) begin : g_row_shift
    assign row_off = (y_ext << 9) + (y_ext << 7);
  end else begin : g_row_mul
    assign row_off = y_ext * ADDR_W'(FG_WIDTH);
  end

  assign s1_valid = active_q && in_range_q;
  assign s1_addr  = fg_base_addr + row_off + ADDR_W'(x_q);

endmodule

// File: rtl/fg_sram_reader.sv
// Foreground fetch: issues SRAM reads (or reuses/drops them) and returns pixels at fixed latency.
module fg_sram_reader
  import fg_pkg::*;
#(
  parameter int unsigned FETCH_LATENCY     = 4,
  parameter int unsigned SRAM_READ_LATENCY = 2,
  parameter int unsigned FG_WIDTH          = FG_WIDTH_DEF,
  parameter int unsigned FG_HEIGHT         = FG_HEIGHT_DEF,
  parameter int unsigned ADDR_W            = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           req_x,
  input  logic [9:0]           req_y,
  input  logic                 req_active,
  input  logic [ADDR_W-1:0]    fg_base_addr,
  fg_sram_reader_if.master     sram,
  output logic [PIXEL_W-1:0]   fg_pixel,
  output logic                 fg_pixel_skip,
  output logic [15:0]          drop_count
);

  localparam int unsigned TagDepth = SRAM_READ_LATENCY + 1;

  if (FETCH_LATENCY != SRAM_READ_LATENCY + 2) begin : g_bad_latency
    $error("FETCH_LATENCY must equal SRAM_READ_LATENCY + 2");
  end

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;

  fg_addr_gen #(
    .ADDR_W    (ADDR_W),
    .FG_WIDTH  (FG_WIDTH),
    .FG_HEIGHT (FG_HEIGHT)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_active   (req_active),
    .fg_base_addr (fg_base_addr),
    .s1_valid     (s1_valid),
    .s1_addr      (s1_addr)
  );

  fg_tag_e            tag_d;
  fg_tag_e            tag_pipe_q [TagDepth];
  logic [ADDR_W-1:0]  sram_addr_d, sram_addr_q;
  logic               rd_en_d, rd_en_q;
  logic [ADDR_W-1:0]  last_addr_d, last_addr_q;
  logic               last_ok_d, last_ok_q;
  logic [15:0]        drop_count_d, drop_count_q;
  logic [PIXEL_W-1:0] rdata_q;
  logic [PIXEL_W-1:0] pixel_d, pixel_q;
  logic               skip_d, skip_q;

  always_comb begin
    // Reuse outranks busy: a duplicate pixel never needs the SRAM.
    tag_d = TAG_READ;
    if (!s1_valid) begin
      tag_d = TAG_INVALID;
    end else if (last_ok_q && (s1_addr == last_addr_q)) begin
      tag_d = TAG_REUSE;
    end else if (sram.sram_busy) begin
      tag_d = TAG_DROP;
    end

    sram_addr_d  = sram_addr_q;
    rd_en_d      = 1'b0;
    last_addr_d  = last_addr_q;
    last_ok_d    = 1'b0;
    drop_count_d = drop_count_q;
    unique case (tag_d)
      TAG_READ: begin
        sram_addr_d = s1_addr;
        rd_en_d     = 1'b1;
        last_addr_d = s1_addr;
        last_ok_d   = 1'b1;
      end
      TAG_REUSE: begin
        last_addr_d = s1_addr;
        last_ok_d   = 1'b1;
      end
      TAG_DROP: begin
        if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      end
      default: ;
    endcase

    pixel_d = pixel_q;
    skip_d  = 1'b1;
    unique case (tag_pipe_q[TagDepth-1])
      TAG_READ: begin
        pixel_d = rdata_q;
        skip_d  = 1'b0;
      end
      TAG_REUSE: skip_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_q  <= '0;
      rd_en_q      <= 1'b0;
      last_addr_q  <= '0;
      last_ok_q    <= 1'b0;
      drop_count_q <= '0;
      rdata_q      <= '0;
      pixel_q      <= '0;
      skip_q       <= 1'b1;
      for (int unsigned i = 0; i < TagDepth; i++) tag_pipe_q[i] <= TAG_INVALID;
    end else begin
      sram_addr_q  <= sram_addr_d;
      rd_en_q      <= rd_en_d;
      last_addr_q  <= last_addr_d;
      last_ok_q    <= last_ok_d;
      drop_count_q <= drop_count_d;
      rdata_q      <= sram.sram_rdata;
      pixel_q      <= pixel_d;
      skip_q       <= skip_d;
      tag_pipe_q[0] <= tag_d;
      for (int unsigned i = 1; i < TagDepth; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  assign sram.sram_addr  = sram_addr_q;
  assign sram.sram_rd_en = rd_en_q;
  assign fg_pixel        = pixel_q;
  assign fg_pixel_skip   = skip_q;
  assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_fg_sram_reader.sv
// Directed plus randomized bench for fg_sram_reader against a transaction-level reference model.
module tb_fg_sram_reader;
  import fg_pkg::*;

  localparam int unsigned AddrW = 19;
  localparam int KSkip  = 0;
  localparam int KRead  = 1;
  localparam int KReuse = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       req_x, req_y;
  logic             req_active;
  logic [AddrW-1:0] fg_base_addr;
  logic [15:0]      fg_pixel;
  logic             fg_pixel_skip;
  logic [15:0]      drop_count;

  fg_sram_reader_if #(.ADDR_W(AddrW)) sram_bus ();

  fg_sram_reader #(
    .FETCH_LATENCY     (4),
    .SRAM_READ_LATENCY (2),
    .FG_WIDTH          (640),
    .FG_HEIGHT         (480),
    .ADDR_W            (AddrW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_active    (req_active),
    .fg_base_addr  (fg_base_addr),
    .sram          (sram_bus.master),
    .fg_pixel      (fg_pixel),
    .fg_pixel_skip (fg_pixel_skip),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sram_word(input logic [AddrW-1:0] a);
    return a[15:0];
  endfunction

  // SRAM: data for the strobed address appears after one register; junk otherwise.
  always @(posedge clk) begin
    if (sram_bus.sram_rd_en) sram_bus.sram_rdata <= sram_word(sram_bus.sram_addr);
    else                     sram_bus.sram_rdata <= 16'($urandom);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted request becomes an outcome that surfaces four edges later.
  typedef struct packed {
    logic [1:0]       kind;
    logic [AddrW-1:0] addr;
  } pend_t;

  pend_t            pend_q[$];
  logic [9:0]       m_prev_x, m_prev_y;
  logic             m_prev_act;
  logic [AddrW-1:0] m_last_addr, m_sram_addr;
  logic             m_last_ok, m_rd_en, m_skip;
  logic [15:0]      m_pixel, m_drop;
  int               reads_seen;

  task automatic model_edge();
    pend_t       p, o;
    int unsigned a;
    if (rst) begin
      pend_q.delete();
      for (int i = 0; i < 3; i++) pend_q.push_back('{kind: 2'(KSkip), addr: '0});
      m_prev_act = 1'b0;
      m_last_ok  = 1'b0;
      m_rd_en    = 1'b0;
      m_sram_addr = '0;
      m_pixel    = '0;
      m_skip     = 1'b1;
      m_drop     = '0;
      return;
    end
    a = 32'(fg_base_addr) + 32'(m_prev_y) * 640 + 32'(m_prev_x);
    p.addr = a[AddrW-1:0];
    m_rd_en = 1'b0;
    if (!(m_prev_act && m_prev_x < 640 && m_prev_y < 480)) begin
      p.kind = 2'(KSkip);
      m_last_ok = 1'b0;
    end else if (m_last_ok && p.addr == m_last_addr) begin
      p.kind = 2'(KReuse);
    end else if (sram_bus.sram_busy) begin
      p.kind = 2'(KSkip);
      m_last_ok = 1'b0;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end else begin
      p.kind = 2'(KRead);
      m_rd_en = 1'b1;
      m_sram_addr = p.addr;
      m_last_ok = 1'b1;
      m_last_addr = p.addr;
    end
    pend_q.push_back(p);
    o = pend_q.pop_front();
    if (o.kind == 2'(KRead)) begin
      m_pixel = sram_word(o.addr);
      m_skip  = 1'b0;
    end else begin
      m_skip = (o.kind != 2'(KReuse));
    end
    m_prev_x   = req_x;
    m_prev_y   = req_y;
    m_prev_act = req_active;
  endtask

  task automatic step(input int x, input int y, input bit act, input bit busy, input bit rst_v);
    @(negedge clk);
    req_x = 10'(x);
    req_y = 10'(y);
    req_active = act;
    sram_bus.sram_busy = busy;
    rst = rst_v;
    @(posedge clk);
    model_edge();
    #1;
    if (sram_bus.sram_rd_en) reads_seen++;
    check_eq("skip", 32'(fg_pixel_skip), 32'(m_skip));
    check_eq("pixel", 32'(fg_pixel), 32'(m_pixel));
    check_eq("rd_en", 32'(sram_bus.sram_rd_en), 32'(m_rd_en));
    check_eq("sram_addr", 32'(sram_bus.sram_addr), 32'(m_sram_addr));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int x, y;
    rst = 1'b1;
    req_x = '0;
    req_y = '0;
    req_active = 1'b0;
    fg_base_addr = '0;
    sram_bus.sram_busy = 1'b0;
    reads_seen = 0;

    // Ramp with base 0: data equals address, skip held for the first four outputs.
    step(0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(i, 0, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Triple duplicate with writer busy afterwards: one read at 1285, reused twice.
    reads_seen = 0;
    step(5, 2, 1'b1, 1'b0, 1'b0);
    step(5, 2, 1'b1, 1'b0, 1'b0);
    step(5, 2, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check_eq("dup_reads", 32'(reads_seen), 32'd1);
    check_eq("dup_drops", 32'(drop_count), 32'd0);

    // Dropped read, then a normal one.
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(7, 0, 1'b1, 1'b0, 1'b0);
    step(8, 0, 1'b1, 1'b1, 1'b0);
    idle(5);
    check_eq("drop_one", 32'(drop_count), 32'd1);

    // Saturation: preset the counter to all-ones, then drop once more.
    @(negedge clk);
    force dut.drop_count_q = 16'hFFFF;
    m_drop = 16'hFFFF;
    step(7, 0, 1'b1, 1'b0, 1'b0);
    release dut.drop_count_q;
    step(9, 0, 1'b1, 1'b1, 1'b0);
    idle(5);
    check_eq("drop_sat", 32'(drop_count), 32'h0000_FFFF);

    // Out-of-range and inactive requests break the reuse chain.
    reads_seen = 0;
    step(3, 3, 1'b1, 1'b0, 1'b0);
    step(640, 0, 1'b1, 1'b0, 1'b0);
    step(3, 3, 1'b1, 1'b0, 1'b0);
    step(0, 480, 1'b1, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0, 1'b0);
    step(3, 3, 1'b1, 1'b0, 1'b0);
    idle(5);
    check_eq("chain_reads", 32'(reads_seen), 32'd3);

    // Reset while reads are in flight.
    fg_base_addr = 19'h00100;
    for (int i = 0; i < 3; i++) step(10 + i, 1, 1'b1, 1'b0, 1'b0);
    step(13, 1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(20 + i, 1, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Randomized traffic with repeats, edge coordinates, busy and rare resets.
    x = 0;
    y = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 64 == 0) fg_base_addr = 19'($urandom);
      if ($urandom_range(0, 99) >= 35) begin
        x = ($urandom_range(0, 9) == 0) ? 638 + $urandom_range(0, 3) : $urandom_range(0, 7);
        y = ($urandom_range(0, 9) == 0) ? 478 + $urandom_range(0, 3) : $urandom_range(0, 3);
      end
      step(x, y, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fg_sram_reader.md
Name: fg_sram_reader

Overview:
- Foreground fetch stage directly upstream of the compositing pipeline.
- Accepts the per-pixel foreground request coordinate and active flag, and turns it into an SRAM read address.
- Returns the 16-bit foreground pixel plus a skip flag exactly FETCH_LATENCY cycles after the request, so the compositor's background delay line stays aligned.
- Shares the SRAM with a frame writer that has priority. Reads denied by the writer are dropped, never retried. A one-entry reuse path covers duplicated (scaled) pixels.

Parameters:
- FETCH_LATENCY, 4, request-to-output delay in cycles; must equal SRAM_READ_LATENCY + 2 (elaboration error otherwise).
- SRAM_READ_LATENCY, 2, cycles from sram_rd_en/sram_addr driven to sram_rdata valid.
- FG_WIDTH, 640, foreground frame width in pixels (row stride).
- FG_HEIGHT, 480, foreground frame height in pixels.
- ADDR_W, 19, SRAM word address width.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_x  in  10  requested foreground x.
- req_y  in  10  requested foreground y.
- req_active  in  1  request valid this cycle.
- fg_base_addr  in  ADDR_W  SRAM word address of foreground pixel (0,0).
- sram_busy  in  1  writer owns SRAM this cycle; read must not issue.
- sram_addr  out  ADDR_W  registered read address.
- sram_rd_en  out  1  registered read strobe.
- sram_rdata  in  16  read data.
- fg_pixel  out  16  registered foreground pixel, RGB565.
- fg_pixel_skip  out  1  registered; 1 = no valid pixel this cycle.
- drop_count  out  16  saturating count of reads dropped due to sram_busy.

Behaviour:
- Reset values: sram_addr=0, sram_rd_en=0, fg_pixel=0, fg_pixel_skip=1, drop_count=0. All in-flight tags are cleared and the reuse register is invalidated.
- After reset deassertion, or after reset asserted mid-stream, the first FETCH_LATENCY outputs are skip=1.
- Stage S0 (edge k):
  - register req_x, req_y, req_active.
  - in_range = req_x < FG_WIDTH and req_y < FG_HEIGHT.
- Stage S1 (edge k+1):
  - addr = fg_base_addr + req_y*FG_WIDTH + req_x, truncated to ADDR_W (wrap-around allowed, no error).
  - For FG_WIDTH=640, multiply as (y<<9)+(y<<7); no DSP multiplier.
- Issue classification at S1, evaluated in this priority order, exactly one tag per cycle:
  - INVALID: not active or not in_range. No read issued.
  - REUSE: addr equals last_addr and last_ok=1. No read issued, even if sram_busy=1.
  - DROP: sram_busy=1. No read issued; drop_count += 1, saturating at 16'hFFFF.
  - READ: otherwise. sram_addr<=addr, sram_rd_en<=1.
- When no read issues, sram_rd_en<=0 and sram_addr holds its value.
- last_addr<=addr and last_ok<=1 on READ or REUSE. last_ok<=0 on INVALID or DROP.
- Tag (2-bit enum) travels a shift register of length SRAM_READ_LATENCY+1, aligned with the data.
- Output stage (edge k+FETCH_LATENCY):
  - READ: fg_pixel<=sram_rdata (sampled at edge k+1+SRAM_READ_LATENCY), skip<=0.
  - REUSE: fg_pixel holds its previous value, skip<=0.
  - INVALID or DROP: fg_pixel holds its value, skip<=1.
- Throughput: one request per cycle, no back-pressure, no stalls; latency is constant regardless of tag.
- sram_busy arriving while a read is in flight does not affect that read; the writer arbiter guarantees this.

Decomposition:
- Shared package fg_pkg holds:
  - tag enum: TAG_INVALID=0, TAG_READ=1, TAG_REUSE=2, TAG_DROP=3.
  - default FG_WIDTH/FG_HEIGHT constants.
  - PIXEL_W=16.
- One sub-module, fg_addr_gen: the combinational bounds check plus the registered address computation (S0–S1).
- Tag pipe, reuse logic and output stage stay in the top module.

Test Plan:
- Reset then active ramp x=0..3, y=0, base=0, SRAM model returns addr as data -> sram_addr 0,1,2,3 on consecutive cycles; fg_pixel 0,1,2,3 with skip=0, each exactly 4 cycles after its request; first 4 outputs after reset skip=1.
- Requests (5,2),(5,2),(5,2) with sram_busy=1 on cycles 2–3 -> one read at addr 1285; outputs are the 1285 data three times, skip=0; drop_count=0.
- Request (7,0) with sram_busy=1, then (8,0) not busy -> first output skip=1, drop_count=1; second output is the addr-8 data. Force drop_count to 16'hFFFF plus one more drop -> stays 16'hFFFF.
- Requests x=640 and y=480 (active=1), and req_active=0 -> no sram_rd_en; outputs skip=1; last_ok cleared, so a following repeat of the prior address issues a real read.
- rst asserted for 1 cycle while 3 reads are in flight -> the next 4 outputs are skip=1 with fg_pixel=0, drop_count=0, and the pipeline resumes correct 4-cycle alignment.
